regfile_sb: RTL
===============

Name: regfile_sb

Overview:
Parametrised successor to the CPU register file, for the pipelined core.
- N combinational read ports with optional same-cycle write-through bypass.
- Hard-wired zero register; trigger-set flag register; debug tap.
- Per-register pending-write scoreboard with a registered outstanding-write counter, so the hazard unit can stall on RAW dependencies.
- Sits between decode (reads, busy set at issue) and writeback (WE3 port).

Parameters:
A_WIDTH, 5, register address width; depth = 2**A_WIDTH
D_WIDTH, 32, data width
NUM_RD, 2, number of read ports (>=1)
TRIG_REG, 5, register forced to 1 when trigger is high
DBG_REG, 10, register driven onto a0
BYPASS, 1, 1 = a read sees same-cycle WD3 and clear-busy; 0 = reads see the stored value only

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  asynchronous active-low reset
trigger  input  1  sets REG[TRIG_REG] to 1 on the next edge
WE3  input  1  writeback enable; also clears the busy bit of A3
A3  input  A_WIDTH  writeback address
WD3  input  D_WIDTH  writeback data
RA  input  NUM_RD*A_WIDTH  packed read addresses, port i at [i*A_WIDTH +: A_WIDTH]
RD  output  NUM_RD*D_WIDTH  packed read data, same packing
RBUSY  output  NUM_RD  port i source has a pending write
ISS_EN  input  1  issue: mark ISS_ADDR busy
ISS_ADDR  input  A_WIDTH  destination of the issuing instruction
FLUSH  input  1  synchronous clear of all busy bits
PEND_CNT  output  A_WIDTH+1  registered count of busy registers
a0  output  D_WIDTH  REG[DBG_REG], stored value, no bypass

Behaviour:
- Reset (RST_N low, asynchronous):
  - All REG entries = 0, all busy bits = 0, PEND_CNT = 0.
  - RD, RBUSY and a0 are combinational, so they read 0 while in reset.
- Register 0:
  - Always reads 0; writes, trigger and ISS_EN to address 0 are ignored.
  - Never busy.
- Reads are combinational, zero latency. For port i with address r = RA[i]:
  - If BYPASS=1 and WE3 and A3==r and r!=0: RD[i] = WD3. Otherwise RD[i] = REG[r].
  - RBUSY[i] = sb[r], except 0 when BYPASS=1 and WE3 and A3==r (the clear is visible in the same cycle).
- Write, at posedge CLK:
  - If WE3 and A3!=0: REG[A3] <= WD3.
  - If trigger and TRIG_REG!=0: REG[TRIG_REG] <= 1. On an A3==TRIG_REG collision, trigger wins.
- Scoreboard update at posedge CLK, per bit j != 0, in this priority order:
  - FLUSH: sb[j] <= 0.
  - Else ISS_EN and ISS_ADDR==j: sb[j] <= 1. Set wins over a same-cycle WE3 clear, because the newer producer is outstanding.
  - Else WE3 and A3==j: sb[j] <= 0.
  - WE3 to a non-busy register writes data and leaves sb unchanged.
  - ISS_EN to an already-busy register keeps it busy, with no double count.
- PEND_CNT, registered:
  - Next value = popcount of the next sb, maintained incrementally as +1/-1/0.
  - FLUSH: next = 0.
  - Range 0 .. 2**A_WIDTH-1; never wraps, since at most 31 bits are settable.
  - Invariant: PEND_CNT == popcount(sb) after every edge.
- Reset asserted mid-operation aborts everything immediately; no write from the same cycle survives.
- Parameter assertions: NUM_RD>=1, TRIG_REG and DBG_REG < 2**A_WIDTH, TRIG_REG != 0.

Decomposition:
- Shared package cpu_pkg:
  - REG_ZERO = 0, REG_A0 = 10, REG_T0 = 5.
  - Type reg_addr_t = logic[A_WIDTH-1:0] and type word_t.
- One natural sub-module, regfile_scoreboard:
  - Holds sb bits, issue/clear/flush priority and PEND_CNT.
  - Inputs: ISS_EN, ISS_ADDR, WE3, A3, FLUSH. Output: sb vector.
- Data array, bypass and the read-port generate loop stay in regfile_sb.

Test Plan:
1. Reset, then read all 32 registers on both ports -> all RD=0, RBUSY=0, PEND_CNT=0, a0=0.
2. WE3=1, A3=10, WD3=0xDEADBEEF, RA0=10 in the same cycle:
   - Same cycle: RD0=0xDEADBEEF (BYPASS=1), a0=0.
   - Next cycle: a0=0xDEADBEEF.
   - With BYPASS=0: RD0=0 in the cycle, 0xDEADBEEF after.
3. WE3=1, A3=0, WD3=0x1234; ISS_EN=1, ISS_ADDR=0 -> REG0 still reads 0, RBUSY=0, PEND_CNT=0.
4. Scoreboard sequence:
   - Issue x7 -> PEND_CNT=1, RBUSY for RA=7 = 1.
   - Issue x7 again -> PEND_CNT stays 1.
   - ISS_EN x7 with WE3 A3=7 in the same cycle -> x7 stays busy, count 1.
   - WE3 A3=7 alone -> busy drops in the same cycle (bypass), count 0.
5. Issue x1..x31 over 31 cycles -> PEND_CNT=31. FLUSH -> PEND_CNT=0, all RBUSY=0. Register data is unchanged.
6. trigger=1 with WE3 A3=5 WD3=0xFF -> REG5=1. Deassert RST_N mid-sequence between edges -> all outputs 0 immediately, before the next clock.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the register file and its scoreboard.
// Provides the architectural register numbers the core refers to by name
// and default-width address/data types.
// Ports: none (package).
package cpu_pkg;

  localparam int A_WIDTH_DEF = 5;
  localparam int D_WIDTH_DEF = 32;

  localparam int REG_ZERO = 0;
  localparam int REG_T0   = 5;
  localparam int REG_A0   = 10;

  typedef logic [A_WIDTH_DEF-1:0] reg_addr_t;
  typedef logic [D_WIDTH_DEF-1:0] word_t;

endpackage : cpu_pkg

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard for the register file.
// One busy bit per register (bit 0 is permanently clear) plus a registered
// count of busy bits, so the hazard unit can stall on RAW dependencies.
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   iss_en/addr    issue: mark the destination register busy
//   we3/a3         writeback: clear the busy bit of a3
//   flush          clear every busy bit
//   sb             busy vector, one bit per register
//   pend_cnt       number of busy registers
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int A_WIDTH = A_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iss_en,
  input  logic [A_WIDTH-1:0]    iss_addr,
  input  logic                  we3,
  input  logic [A_WIDTH-1:0]    a3,
  input  logic                  flush,
  output logic [2**A_WIDTH-1:0] sb,
  output logic [A_WIDTH:0]      pend_cnt
);

  localparam int DEPTH = 2**A_WIDTH;
  localparam logic [A_WIDTH-1:0] ZERO_ADDR = A_WIDTH'(REG_ZERO);
  localparam logic [A_WIDTH:0]   CNT_ONE   = (A_WIDTH+1)'(1);

  logic             set_valid;
  logic             set_new;
  logic             clr_valid;
  logic             clr_hit;
  logic [DEPTH-1:0] sb_next;
  logic [A_WIDTH:0] cnt_next;

  // A clear to the register being issued this cycle is dropped: the newer
  // producer is still outstanding. The count moves only when a bit actually
  // changes, which keeps it equal to popcount(sb) without a full adder tree.
  always_comb begin
    set_valid = iss_en && (iss_addr != ZERO_ADDR);
    set_new   = set_valid && !sb[iss_addr];
    clr_valid = we3 && (a3 != ZERO_ADDR) && !(set_valid && (iss_addr == a3));
    clr_hit   = clr_valid && sb[a3];

    sb_next = sb;
    if (flush) begin
      sb_next = '0;
    end else begin
      if (clr_valid) sb_next[a3] = 1'b0;
      if (set_valid) sb_next[iss_addr] = 1'b1;
    end
    sb_next[0] = 1'b0;

    cnt_next = pend_cnt;
    if (flush) begin
      cnt_next = '0;
    end else if (set_new && !clr_hit) begin
      cnt_next = pend_cnt + CNT_ONE;
    end else if (clr_hit && !set_new) begin
      cnt_next = pend_cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb       <= '0;
      pend_cnt <= '0;
    end else begin
      sb       <= sb_next;
      pend_cnt <= cnt_next;
    end
  end

endmodule : regfile_scoreboard

// File: rtl/regfile_sb.sv
// Parametrised register file for the pipelined core.
// N combinational read ports with optional same-cycle writeback bypass,
// hard-wired zero register, trigger-set flag register, debug tap and a
// pending-write scoreboard for RAW hazard detection.
// Ports:
//   CLK, RST_N         clock (rising edge), asynchronous active-low reset
//   trigger            force REG[TRIG_REG] to 1 on the next edge
//   WE3, A3, WD3       writeback port (also clears busy of A3)
//   RA, RD, RBUSY      packed read ports: address, data, source-busy
//   ISS_EN, ISS_ADDR   issue: mark destination busy
//   FLUSH              clear all busy bits
//   PEND_CNT           registered number of busy registers
//   a0                 stored value of REG[DBG_REG]
module regfile_sb
  import cpu_pkg::*;
#(
  parameter int A_WIDTH  = A_WIDTH_DEF,
  parameter int D_WIDTH  = D_WIDTH_DEF,
  parameter int NUM_RD   = 2,
  parameter int TRIG_REG = REG_T0,
  parameter int DBG_REG  = REG_A0,
  parameter int BYPASS   = 1
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      trigger,
  input  logic                      WE3,
  input  logic [A_WIDTH-1:0]        A3,
  input  logic [D_WIDTH-1:0]        WD3,
  input  logic [NUM_RD*A_WIDTH-1:0] RA,
  output logic [NUM_RD*D_WIDTH-1:0] RD,
  output logic [NUM_RD-1:0]         RBUSY,
  input  logic                      ISS_EN,
  input  logic [A_WIDTH-1:0]        ISS_ADDR,
  input  logic                      FLUSH,
  output logic [A_WIDTH:0]          PEND_CNT,
  output logic [D_WIDTH-1:0]        a0
);

  localparam int DEPTH = 2**A_WIDTH;
  localparam logic [A_WIDTH-1:0] ZERO_ADDR = A_WIDTH'(REG_ZERO);
  localparam logic [A_WIDTH-1:0] TRIG_ADDR = A_WIDTH'(TRIG_REG);
  localparam logic [A_WIDTH-1:0] DBG_ADDR  = A_WIDTH'(DBG_REG);
  localparam logic [D_WIDTH-1:0] ONE_WORD  = D_WIDTH'(1);

  if (NUM_RD < 1) begin : g_chk_rd
    $error("regfile_sb: NUM_RD must be at least 1");
  end
  if (TRIG_REG >= DEPTH || DBG_REG >= DEPTH) begin : g_chk_idx
    $error("regfile_sb: TRIG_REG and DBG_REG must be below 2**A_WIDTH");
  end
  if (TRIG_REG == 0) begin : g_chk_trig
    $error("regfile_sb: TRIG_REG must not be register 0");
  end

  logic [D_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]   sb;

  // Entry 0 is never written, so it holds the reset value of zero forever.
  // The trigger assignment comes last so it wins a collision with A3.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int j = 0; j < DEPTH; j++) mem[j] <= '0;
    end else begin
      if (WE3 && (A3 != ZERO_ADDR)) mem[A3] <= WD3;
      if (trigger) mem[TRIG_ADDR] <= ONE_WORD;
    end
  end

  regfile_scoreboard #(
    .A_WIDTH (A_WIDTH)
  ) u_scoreboard (
    .clk      (CLK),
    .rst_n    (RST_N),
    .iss_en   (ISS_EN),
    .iss_addr (ISS_ADDR),
    .we3      (WE3),
    .a3       (A3),
    .flush    (FLUSH),
    .sb       (sb),
    .pend_cnt (PEND_CNT)
  );

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [A_WIDTH-1:0] r;
    logic               hit;
    logic [D_WIDTH-1:0] rd_i;
    logic               busy_i;

    assign r   = RA[i*A_WIDTH +: A_WIDTH];
    assign hit = (BYPASS != 0) && WE3 && (A3 == r);

    // Outputs are forced to zero during reset so a writeback held on the
    // bus while RST_N is low cannot leak through the bypass path.
    always_comb begin
      rd_i   = '0;
      busy_i = 1'b0;
      if (RST_N) begin
        rd_i   = (hit && (r != ZERO_ADDR)) ? WD3 : mem[r];
        busy_i = hit ? 1'b0 : sb[r];
      end
    end

    assign RD[i*D_WIDTH +: D_WIDTH] = rd_i;
    assign RBUSY[i]                 = busy_i;
  end

  assign a0 = mem[DBG_ADDR];

endmodule : regfile_sb
